mac_int_vec_fsm: RTL and testbench



---
 rtl/mac_int_vec_fsm_if.sv | 24 ++
 rtl/mac_int_vec_fsm.sv | 164 ++++++++++++++++
 tb/tb_mac_int_vec_fsm.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mac_int_vec_fsm_if.sv
// Operand/result handshake bundle of the vector MAC: operand pairs in, dot products out.
interface mac_int_vec_fsm_if #(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  y;
    logic              ovf;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, y, ovf
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, y, ovf
    );
endinterface

// File: rtl/mac_int_vec_fsm.sv
// Integer dot-product engine: accumulates cfg_len operand products and hands the
// saturated or truncated sum downstream on a valid/ready handshake.
module mac_int_vec_fsm #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int OUT_W  = 32,
    parameter int LEN_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_signed,
    input  logic             cfg_sat,
    mac_int_vec_fsm_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t           state_r;
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] prod_r;
    logic             p_vld_r;
    logic [LEN_W-1:0] cnt_r;
    logic [LEN_W-1:0] len_r;
    logic             sgn_r;
    logic             sat_r;
    logic [OUT_W-1:0] y_r;
    logic             ovf_r;
    logic             out_valid_r;

    logic [ACC_W-1:0] sum_s;
    logic [ACC_W-1:0] prod_s;
    logic [LEN_W-1:0] eff_len_s;
    logic [LEN_W-1:0] cnt_nxt_s;
    logic [OUT_W:0]   res_s;

    function automatic logic [ACC_W-1:0] ext_op(input logic [DATA_W-1:0] v, input logic sgn);
        ext_op = {{(ACC_W-DATA_W){sgn & v[DATA_W-1]}}, v};
    endfunction

    // Products are formed at accumulator width so signed values wrap correctly modulo 2^ACC_W.
    function automatic logic [ACC_W-1:0] mul_op(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic sgn);
        mul_op = ext_op(a, sgn) * ext_op(b, sgn);
    endfunction

    // Returns {ovf, y}: ovf flags a sum that does not fit OUT_W in the selected mode.
    function automatic logic [OUT_W:0] fit_result(input logic [ACC_W-1:0] sum,
                                                  input logic sgn,
                                                  input logic sat);
        logic [ACC_W-1:0] hi_v;
        logic             fits_v;
        logic [OUT_W-1:0] clamp_v;
        if (sgn) begin
            hi_v    = ACC_W'($signed(sum) >>> (OUT_W - 1));
            fits_v  = (hi_v == {ACC_W{1'b0}}) || (hi_v == {ACC_W{1'b1}});
            clamp_v = sum[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end else begin
            hi_v    = sum >> OUT_W;
            fits_v  = (hi_v == {ACC_W{1'b0}});
            clamp_v = {OUT_W{1'b1}};
        end
        fit_result = {~fits_v, (sat && !fits_v) ? clamp_v : sum[OUT_W-1:0]};
    endfunction

    // Datapath helpers: next sum, incoming product and effective vector length.
    always_comb begin
        sum_s     = acc_r + prod_r;
        prod_s    = mul_op(bus.A, bus.B, (state_r == IDLE) ? cfg_signed : sgn_r);
        eff_len_s = (cfg_len == {LEN_W{1'b0}}) ? LEN_ONE : cfg_len;
        cnt_nxt_s = cnt_r + LEN_ONE;
        res_s     = fit_result(sum_s, sgn_r, sat_r);
    end

    assign bus.in_ready  = reset & ((state_r == IDLE) | (state_r == ACCUM));
    assign bus.out_valid = out_valid_r;
    assign bus.y         = y_r;
    assign bus.ovf       = ovf_r;

    // Control FSM with accumulator, product pipeline register and registered result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= IDLE;
            acc_r       <= {ACC_W{1'b0}};
            prod_r      <= {ACC_W{1'b0}};
            p_vld_r     <= 1'b0;
            cnt_r       <= {LEN_W{1'b0}};
            len_r       <= LEN_ONE;
            sgn_r       <= 1'b0;
            sat_r       <= 1'b0;
            y_r         <= {OUT_W{1'b0}};
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (clear) begin
            // Abort drops the partial sum but keeps the last delivered result visible.
            state_r     <= IDLE;
            acc_r       <= {ACC_W{1'b0}};
            p_vld_r     <= 1'b0;
            cnt_r       <= {LEN_W{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        len_r   <= eff_len_s;
                        sgn_r   <= cfg_signed;
                        sat_r   <= cfg_sat;
                        acc_r   <= {ACC_W{1'b0}};
                        prod_r  <= prod_s;
                        p_vld_r <= 1'b1;
                        cnt_r   <= LEN_ONE;
                        state_r <= (eff_len_s == LEN_ONE) ? DRAIN : ACCUM;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCUM: begin
                    if (p_vld_r) begin
                        acc_r <= sum_s;
                    end else begin
                        acc_r <= acc_r;
                    end
                    if (bus.in_valid) begin
                        prod_r  <= prod_s;
                        p_vld_r <= 1'b1;
                        cnt_r   <= cnt_nxt_s;
                        state_r <= (cnt_nxt_s == len_r) ? DRAIN : ACCUM;
                    end else begin
                        p_vld_r <= 1'b0;
                    end
                end
                DRAIN: begin
                    {ovf_r, y_r} <= res_s;
                    acc_r        <= sum_s;
                    p_vld_r      <= 1'b0;
                    out_valid_r  <= 1'b1;
                    state_r      <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_int_vec_fsm.sv
// Randomised and directed bench for mac_int_vec_fsm against an arithmetic dot-product model.
module tb_mac_int_vec_fsm;

    localparam int DATA_W = 16;
    localparam int ACC_W  = 40;
    localparam int OUT_W  = 32;
    localparam int LEN_W  = 8;

    logic             clk        = 1'b0;
    logic             reset      = 1'b0;
    logic             clear      = 1'b0;
    logic [LEN_W-1:0] cfg_len    = 8'd0;
    logic             cfg_signed = 1'b0;
    logic             cfg_sat    = 1'b0;

    mac_int_vec_fsm_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

    mac_int_vec_fsm #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .LEN_W(LEN_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .cfg_len   (cfg_len),
        .cfg_signed(cfg_signed),
        .cfg_sat   (cfg_sat),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] va [256];
    logic [15:0] vb [256];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer dot product, then range test against the OUT_W window.
    function automatic logic [32:0] model(input int n, input bit sgn, input bit sat);
        longint s = 0;
        longint lo;
        longint hi;
        bit     of;
        for (int i = 0; i < n; i++) begin
            if (sgn) s += longint'($signed(va[i])) * longint'($signed(vb[i]));
            else     s += longint'(va[i]) * longint'(vb[i]);
        end
        lo = sgn ? -64'sd2147483648 : 64'sd0;
        hi = sgn ?  64'sd2147483647 : 64'sd4294967295;
        of = (s < lo) || (s > hi);
        if (sat && of) s = (s > hi) ? hi : lo;
        return {of, s[31:0]};
    endfunction

    function automatic logic [15:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            2:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feeds va/vb[0..n-1]; gap<0 or stall<0 pick random bubbles / backpressure.
    task automatic run_vec(input string tag, input int n, input logic [7:0] len_cfg,
                           input bit sgn, input bit sat, input int gap, input int stall,
                           input bit release_it);
        logic [32:0] exp;
        int          g;
        int          st;
        exp        = model(n, sgn, sat);
        cfg_len    = len_cfg;
        cfg_signed = sgn;
        cfg_sat    = sat;
        bus.out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            g = (i == 0) ? 0 : ((gap < 0) ? int'($urandom_range(0, 2)) : gap);
            bus.in_valid = 1'b0;
            repeat (g) tick();
            bus.in_valid = 1'b1;
            bus.A = va[i];
            bus.B = vb[i];
            check_eq({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
            tick();
            // Config is latched on the first beat; later changes must not matter.
            cfg_len    = 8'($urandom);
            cfg_signed = 1'($urandom);
            cfg_sat    = 1'($urandom);
        end
        bus.in_valid = 1'b0;
        check_eq({tag, ".early_valid"}, 64'(bus.out_valid), 64'd0);
        tick();
        check_eq({tag, ".out_valid"}, 64'(bus.out_valid), 64'd1);
        check_eq({tag, ".y"}, 64'(bus.y), 64'(exp[31:0]));
        check_eq({tag, ".ovf"}, 64'(bus.ovf), 64'(exp[32]));
        check_eq({tag, ".done_ready"}, 64'(bus.in_ready), 64'd0);
        st = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
        repeat (st) begin
            tick();
            check_eq({tag, ".hold_valid"}, 64'(bus.out_valid), 64'd1);
            check_eq({tag, ".hold_y"}, 64'(bus.y), 64'(exp[31:0]));
            check_eq({tag, ".hold_ready"}, 64'(bus.in_ready), 64'd0);
        end
        if (release_it) begin
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            check_eq({tag, ".rel_valid"}, 64'(bus.out_valid), 64'd0);
            check_eq({tag, ".rel_ready"}, 64'(bus.in_ready), 64'd1);
        end
    endtask

    initial begin
        logic [32:0] exp_keep;
        int          n;
        bus.in_valid  = 1'b0;
        bus.A         = 16'd0;
        bus.B         = 16'd0;
        bus.out_ready = 1'b0;

        reset = 1'b0;
        tick();
        tick();
        check_eq("rst.in_ready", 64'(bus.in_ready), 64'd0);
        check_eq("rst.out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst.y", 64'(bus.y), 64'd0);
        check_eq("rst.ovf", 64'(bus.ovf), 64'd0);
        reset = 1'b1;
        #1;
        check_eq("rst.idle_ready", 64'(bus.in_ready), 64'd1);

        va[0] = 16'd3;    vb[0] = 16'd4;
        va[1] = 16'hFFFE; vb[1] = 16'd5;
        va[2] = 16'd7;    vb[2] = 16'hFFFF;
        va[3] = 16'd100;  vb[3] = 16'd100;
        run_vec("t1", 4, 8'd4, 1'b1, 1'b0, 0, 0, 1'b1);

        va[0] = 16'hFFFF; vb[0] = 16'hFFFF;
        va[1] = 16'hFFFF; vb[1] = 16'hFFFF;
        run_vec("t2sat", 2, 8'd2, 1'b0, 1'b1, 0, 1, 1'b1);
        run_vec("t2trn", 2, 8'd2, 1'b0, 1'b0, 0, 1, 1'b1);

        for (int i = 0; i < 3; i++) begin
            va[i] = 16'h8000;
            vb[i] = 16'h8000;
        end
        run_vec("t3len3", 3, 8'd3, 1'b1, 1'b1, 0, 0, 1'b1);
        run_vec("t3len1", 1, 8'd1, 1'b1, 1'b1, 0, 0, 1'b1);

        va[0] = 16'd2; vb[0] = 16'd3;
        va[1] = 16'd4; vb[1] = 16'd5;
        va[2] = 16'd6; vb[2] = 16'd7;
        run_vec("t4", 3, 8'd3, 1'b1, 1'b0, 1, 5, 1'b1);

        // Abort a len=5 vector after two beats.
        cfg_len = 8'd5; cfg_signed = 1'b1; cfg_sat = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.A = 16'h1234;
            bus.B = 16'h0F0F;
            tick();
        end
        bus.in_valid = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_eq("t5.clr_ready", 64'(bus.in_ready), 64'd1);
        repeat (4) begin
            tick();
            check_eq("t5.no_result", 64'(bus.out_valid), 64'd0);
        end
        va[0] = 16'd5; vb[0] = 16'd6;
        run_vec("t5", 1, 8'd0, 1'b1, 1'b0, 0, 0, 1'b1);

        // Clear while a result is pending keeps y/ovf but drops out_valid.
        for (int i = 0; i < 2; i++) begin
            va[i] = 16'h7FFF;
            vb[i] = 16'h7FFF;
        end
        exp_keep = model(2, 1'b1, 1'b1);
        run_vec("t5b", 2, 8'd2, 1'b1, 1'b1, 0, 0, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_eq("t5b.clr_valid", 64'(bus.out_valid), 64'd0);
        check_eq("t5b.clr_y", 64'(bus.y), 64'(exp_keep[31:0]));
        check_eq("t5b.clr_ovf", 64'(bus.ovf), 64'(exp_keep[32]));
        check_eq("t5b.clr_ready", 64'(bus.in_ready), 64'd1);

        // Reset from DONE.
        run_vec("t6", 2, 8'd2, 1'b0, 1'b0, 0, 0, 1'b0);
        reset = 1'b0;
        #1;
        check_eq("t6.rst_ready", 64'(bus.in_ready), 64'd0);
        tick();
        check_eq("t6.y", 64'(bus.y), 64'd0);
        check_eq("t6.ovf", 64'(bus.ovf), 64'd0);
        check_eq("t6.out_valid", 64'(bus.out_valid), 64'd0);
        reset = 1'b1;
        #1;
        check_eq("t6.idle_ready", 64'(bus.in_ready), 64'd1);

        for (int v = 0; v < 40; v++) begin
            n = (v % 10 == 9) ? int'($urandom_range(10, 24)) : int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++) begin
                va[i] = rnd_op();
                vb[i] = rnd_op();
            end
            run_vec("rnd", n, (n == 1 && $urandom_range(0, 1) == 0) ? 8'd0 : 8'(n),
                    1'($urandom), 1'($urandom), -1, -1, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
